multi_cycle_control: RTL and testbench

Multi-cycle MIPS control unit sitting directly upstream of the register file: it sequences fetch/decode/execute/memory/write-back and drives the file's `Register_Write` strobe and write-address select (`Reg_Dst`), plus datapath muxes, ALU op class, memory strobes and PC enable. Opcode and funct come from the instruction register, which this block loads. Memory may stall via `Mem_Ready`.

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/multi_cycle_control_if.sv | 37 +++
 rtl/control_output_decode.sv | 64 ++++++
 rtl/multi_cycle_control.sv | 94 +++++++++
 tb/tb_multi_cycle_control.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU/mux select codes and the packed control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] FUNCT_JR = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_source_t;

  // One cycle's worth of datapath controls, decoded from the current state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       register_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_word_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, strobes and selects out.
interface multi_cycle_control_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]    Opcode;
  logic [OP_W-1:0]    Funct;
  logic               Zero;
  logic               Mem_Ready;

  logic               PC_En;
  logic               IorD;
  logic               Mem_Read;
  logic               Mem_Write;
  logic               IR_Write;
  logic               Reg_Dst;
  logic               Mem_To_Reg;
  logic               Register_Write;
  logic               ALU_Src_A;
  logic [1:0]         ALU_Src_B;
  logic [1:0]         ALU_Op;
  logic [1:0]         PC_Source;
  logic               Illegal_Op;
  logic [STATE_W-1:0] State;

  modport master (
    output Opcode, Funct, Zero, Mem_Ready,
    input  PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_To_Reg,
           Register_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source, Illegal_Op, State
  );

  modport slave (
    input  Opcode, Funct, Zero, Mem_Ready,
    output PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_To_Reg,
           Register_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Source, Illegal_Op, State
  );

endinterface

// File: rtl/control_output_decode.sv
// Moore decode of FSM state into the datapath control word; FETCH only
// commits IR/PC once memory has delivered the instruction.
module control_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.register_write = 1'b1;
        cw.mem_to_reg     = 1'b1;
      end
      S_MEM_WRITE: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_R_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        cw.register_write = 1'b1;
        cw.reg_dst        = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALU_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        cw.register_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and
// reset-gated control outputs toward the datapath and register file.
module multi_cycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  multi_cycle_control_if.slave  bus
);

  state_t     state, state_nxt;
  logic       is_store, is_store_nxt;
  logic       illegal_c;
  ctrl_word_t cw_raw;
  ctrl_word_t cw;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state    <= state_nxt;
      is_store <= is_store_nxt;
    end
  end

  // Opcode is only looked at in DECODE; lw/sw is remembered for MEM_ADDR.
  always_comb begin
    state_nxt    = state;
    is_store_nxt = is_store;
    illegal_c    = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.Mem_Ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        is_store_nxt = (bus.Opcode == OP_SW);
        case (bus.Opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE: begin
            if (bus.Funct == FUNCT_JR) begin
              state_nxt = S_FETCH;
              illegal_c = 1'b1;
            end else begin
              state_nxt = S_R_EXEC;
            end
          end
          OP_BEQ:  state_nxt = S_BRANCH;
          OP_ADDI: state_nxt = S_ADDI_EXEC;
          OP_J:    state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_nxt = is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.Mem_Ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        if (bus.Mem_Ready) state_nxt = S_FETCH;
      end
      S_R_EXEC:    state_nxt = S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      default:     state_nxt = S_FETCH;
    endcase
  end

  control_output_decode u_decode (
    .state     (state),
    .mem_ready (bus.Mem_Ready),
    .cw        (cw_raw)
  );

  // Reset silences every strobe immediately, even mid-instruction.
  assign cw = Reset_n ? cw_raw : '0;

  assign bus.PC_En          = cw.pc_write | (cw.pc_write_cond & bus.Zero);
  assign bus.IorD           = cw.iord;
  assign bus.Mem_Read       = cw.mem_read;
  assign bus.Mem_Write      = cw.mem_write;
  assign bus.IR_Write       = cw.ir_write;
  assign bus.Reg_Dst        = cw.reg_dst;
  assign bus.Mem_To_Reg     = cw.mem_to_reg;
  assign bus.Register_Write = cw.register_write;
  assign bus.ALU_Src_A      = cw.alu_src_a;
  assign bus.ALU_Src_B      = cw.alu_src_b;
  assign bus.ALU_Op         = cw.alu_op;
  assign bus.PC_Source      = cw.pc_source;
  assign bus.Illegal_Op     = Reset_n & illegal_c;
  assign bus.State          = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class through
// the FSM and checks state plus the full control vector every cycle.
module tb_multi_cycle_control;

  logic Clk = 1'b0;
  logic Reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  multi_cycle_control_if bus ();

  multi_cycle_control dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // {PC_En,IorD,Mem_Read,Mem_Write,IR_Write,Reg_Dst,Mem_To_Reg,Register_Write,
  //  ALU_Src_A,ALU_Src_B[1:0],ALU_Op[1:0],PC_Source[1:0],Illegal_Op}
  logic [15:0] obs;
  assign obs = {bus.PC_En, bus.IorD, bus.Mem_Read, bus.Mem_Write, bus.IR_Write,
                bus.Reg_Dst, bus.Mem_To_Reg, bus.Register_Write, bus.ALU_Src_A,
                bus.ALU_Src_B, bus.ALU_Op, bus.PC_Source, bus.Illegal_Op};

  function automatic logic [15:0] mk(input int pc_en, input int iord, input int mr,
                                     input int mw, input int irw, input int rd,
                                     input int m2r, input int rw, input int srca,
                                     input int srcb, input int aluop, input int pcsrc,
                                     input int ill);
    return {1'(pc_en), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rd), 1'(m2r), 1'(rw),
            1'(srca), 2'(srcb), 2'(aluop), 2'(pcsrc), 1'(ill)};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic at_state(input string tag, input logic [3:0] st, input logic [15:0] cv);
    #1;
    check({tag, "/state"}, 16'(bus.State), 16'(st));
    check({tag, "/ctrl"}, obs, cv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  logic [15:0] C_FETCH, C_FETCH_W, C_DECODE, C_DECODE_ILL, C_MEM_ADDR, C_MEM_READ,
               C_MEM_WB, C_MEM_WRITE, C_R_EXEC, C_R_WB, C_BR_T, C_BR_N, C_JUMP, C_ADDI_WB;

  initial begin
    //                 pce iod mr mw irw rd m2r rw sa sb op ps ill
    C_FETCH      = mk(1,  0,  1, 0, 1,  0, 0,  0, 0, 1, 0, 0, 0);
    C_FETCH_W    = mk(0,  0,  1, 0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
    C_DECODE     = mk(0,  0,  0, 0, 0,  0, 0,  0, 0, 3, 0, 0, 0);
    C_DECODE_ILL = mk(0,  0,  0, 0, 0,  0, 0,  0, 0, 3, 0, 0, 1);
    C_MEM_ADDR   = mk(0,  0,  0, 0, 0,  0, 0,  0, 1, 2, 0, 0, 0);
    C_MEM_READ   = mk(0,  1,  1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    C_MEM_WB     = mk(0,  0,  0, 0, 0,  0, 1,  1, 0, 0, 0, 0, 0);
    C_MEM_WRITE  = mk(0,  1,  0, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    C_R_EXEC     = mk(0,  0,  0, 0, 0,  0, 0,  0, 1, 0, 2, 0, 0);
    C_R_WB       = mk(0,  0,  0, 0, 0,  1, 0,  1, 0, 0, 0, 0, 0);
    C_BR_T       = mk(1,  0,  0, 0, 0,  0, 0,  0, 1, 0, 1, 1, 0);
    C_BR_N       = mk(0,  0,  0, 0, 0,  0, 0,  0, 1, 0, 1, 1, 0);
    C_JUMP       = mk(1,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 2, 0);
    C_ADDI_WB    = mk(0,  0,  0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0);

    Reset_n       = 1'b0;
    bus.Opcode    = 6'b000000;
    bus.Funct     = 6'b100000;
    bus.Zero      = 1'b0;
    bus.Mem_Ready = 1'b1;

    // Reset: everything quiet, even Mem_Read, although the state is FETCH.
    repeat (3) begin
      tick();
      at_state("reset", 4'd0, 16'h0000);
    end

    // R-type: 0,1,6,7,0
    Reset_n = 1'b1;
    at_state("r_fetch", 4'd0, C_FETCH);
    tick(); at_state("r_decode", 4'd1, C_DECODE);
    tick(); at_state("r_exec", 4'd6, C_R_EXEC);
    tick(); at_state("r_wb", 4'd7, C_R_WB);

    // lw with two wait cycles; opcode changed after DECODE must be ignored.
    tick(); bus.Opcode = 6'b100011; at_state("lw_fetch", 4'd0, C_FETCH);
    tick(); at_state("lw_decode", 4'd1, C_DECODE);
    tick(); bus.Opcode = 6'b101011; at_state("lw_addr", 4'd2, C_MEM_ADDR);
    tick(); bus.Mem_Ready = 1'b0; at_state("lw_read_w0", 4'd3, C_MEM_READ);
    tick(); at_state("lw_read_w1", 4'd3, C_MEM_READ);
    tick(); bus.Mem_Ready = 1'b1; at_state("lw_read_rdy", 4'd3, C_MEM_READ);
    tick(); at_state("lw_wb", 4'd4, C_MEM_WB);

    // FETCH wait cycle, then sw: 0,1,2,5,0
    tick(); bus.Mem_Ready = 1'b0; at_state("sw_fetch_wait", 4'd0, C_FETCH_W);
    tick(); bus.Mem_Ready = 1'b1; at_state("sw_fetch", 4'd0, C_FETCH);
    tick(); at_state("sw_decode", 4'd1, C_DECODE);
    tick(); at_state("sw_addr", 4'd2, C_MEM_ADDR);
    tick(); at_state("sw_write", 4'd5, C_MEM_WRITE);

    // beq taken (Zero=1), then not taken (Zero=0)
    tick(); bus.Opcode = 6'b000100; bus.Zero = 1'b1; at_state("beq1_fetch", 4'd0, C_FETCH);
    tick(); at_state("beq1_decode", 4'd1, C_DECODE);
    tick(); at_state("beq1_branch", 4'd8, C_BR_T);
    tick(); bus.Zero = 1'b0; at_state("beq0_fetch", 4'd0, C_FETCH);
    tick(); at_state("beq0_decode", 4'd1, C_DECODE);
    tick(); at_state("beq0_branch", 4'd8, C_BR_N);

    // addi: 0,1,10,11,0 (Zero high must not leak into PC_En)
    tick(); bus.Opcode = 6'b001000; bus.Zero = 1'b1; at_state("addi_fetch", 4'd0, C_FETCH);
    tick(); at_state("addi_decode", 4'd1, C_DECODE);
    tick(); at_state("addi_exec", 4'd10, C_MEM_ADDR);
    tick(); at_state("addi_wb", 4'd11, C_ADDI_WB);

    // j, then illegal opcode 111111, then jr (R-type funct 001000)
    tick(); bus.Opcode = 6'b000010; at_state("j_fetch", 4'd0, C_FETCH);
    tick(); at_state("j_decode", 4'd1, C_DECODE);
    tick(); at_state("j_jump", 4'd9, C_JUMP);
    tick(); bus.Opcode = 6'b111111; at_state("ill_fetch", 4'd0, C_FETCH);
    tick(); at_state("ill_decode", 4'd1, C_DECODE_ILL);
    tick(); bus.Opcode = 6'b000000; bus.Funct = 6'b001000; at_state("ill_after", 4'd0, C_FETCH);
    tick(); at_state("jr_decode", 4'd1, C_DECODE_ILL);
    tick(); bus.Funct = 6'b100000; bus.Opcode = 6'b100011; at_state("jr_after", 4'd0, C_FETCH);

    // lw interrupted by reset during MEM_WB
    tick(); at_state("lw2_decode", 4'd1, C_DECODE);
    tick(); at_state("lw2_addr", 4'd2, C_MEM_ADDR);
    tick(); at_state("lw2_read", 4'd3, C_MEM_READ);
    tick(); at_state("lw2_wb", 4'd4, C_MEM_WB);
    Reset_n = 1'b0;
    at_state("lw2_reset_async", 4'd0, 16'h0000);
    tick(); at_state("lw2_reset_hold", 4'd0, 16'h0000);

    // First edge after release samples FETCH normally.
    Reset_n = 1'b1;
    at_state("post_fetch", 4'd0, C_FETCH);
    tick(); at_state("post_decode", 4'd1, C_DECODE);
    tick(); at_state("post_addr", 4'd2, C_MEM_ADDR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
